// File: rtl/boot_loader_if.sv
// Byte-stream and RAM port A signals of the j1 boot loader.
// The slave modport is the loader's view; the master modport is the UART/RAM side.
interface boot_loader_if #(
    parameter int LOG2ABITS = 13,
    parameter int DWIDTH    = 16
);
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic                 mem_we;
    logic [LOG2ABITS-1:0] mem_addr;
    logic [DWIDTH-1:0]    mem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/boot_loader.sv
// Decodes a framed program image from the UART into the j1 code/data RAM and
// holds the CPU in reset until a frame with a good checksum has been written.
module boot_loader #(
    parameter int LOG2ABITS      = 13,
    parameter int DWIDTH         = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          resetq,
    boot_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] MAX_WORDS = 17'(1) << LOG2ABITS;

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, RUN
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          count_q, count_d;
    logic [7:0]           low_q, low_d;
    logic [7:0]           csum_q, csum_d;
    logic [TW-1:0]        timeout_q, timeout_d;
    logic                 mem_we_q, mem_we_d;
    logic [LOG2ABITS-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 rx_ready_q, rx_ready_d;

    logic                 accept;
    logic [15:0]          len_word;
    logic                 last_word;
    logic                 in_frame;

    assign accept    = bus.rx_valid && rx_ready_q;
    assign len_word  = {bus.rx_data, count_q[7:0]};
    assign last_word = (16'(mem_addr_q) == (count_q - 16'd1));
    assign in_frame  = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA_LO) || (state_q == DATA_HI) ||
                       (state_q == CSUM);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        low_d       = low_q;
        csum_d      = csum_q;
        timeout_d   = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        error_d     = error_q;

        // The word index advances once the strobe for the current word has been issued.
        if (mem_we_q) begin
            mem_addr_d = mem_addr_q + LOG2ABITS'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (accept && bus.rx_data == 8'hA5) begin
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    count_d[7:0] = bus.rx_data;
                    state_d      = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    count_d[15:8] = bus.rx_data;
                    csum_d        = '0;
                    mem_addr_d    = '0;
                    error_d       = 1'b0;
                    if (len_word == 16'd0) begin
                        state_d = CSUM;
                    end else if ({1'b0, len_word} > MAX_WORDS) begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end else begin
                        state_d = DATA_LO;
                    end
                end
            end
            DATA_LO: begin
                if (accept) begin
                    low_d   = bus.rx_data;
                    csum_d  = csum_q + bus.rx_data;
                    state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) begin
                    csum_d      = csum_q + bus.rx_data;
                    mem_wdata_d = DWIDTH'({bus.rx_data, low_q});
                    mem_we_d    = 1'b1;
                    state_d     = last_word ? CSUM : DATA_LO;
                end
            end
            CSUM: begin
                if (accept) begin
                    if (bus.rx_data == csum_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An accepted byte always wins over an expiring inter-byte timer.
        if (in_frame && !accept) begin
            if (timeout_q == TO_LAST) begin
                state_d = IDLE;
                error_d = 1'b1;
            end else begin
                timeout_d = timeout_q + TW'(1);
            end
        end

        cpu_reset_d = (state_d != RUN);
        done_d      = (state_d == RUN);
        rx_ready_d  = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q     <= IDLE;
            count_q     <= '0;
            low_q       <= '0;
            csum_q      <= '0;
            timeout_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            rx_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            low_q       <= low_d;
            csum_q      <= csum_d;
            timeout_q   <= timeout_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
            rx_ready_q  <= rx_ready_d;
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign done          = done_q;
    assign error         = error_q;
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a per-cycle vector table for one good frame,
// then hand-written sequences for checksum, length, timeout and reset corners.
module tb_boot_loader;
    logic clk;
    logic resetq;
    logic cpu_reset;
    logic done;
    logic error;

    int checks;
    int errors;
    int we_count;
    int we_before;

    boot_loader_if #(.LOG2ABITS(13), .DWIDTH(16)) bus ();

    boot_loader #(
        .LOG2ABITS(13),
        .DWIDTH(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .resetq(resetq),
        .bus(bus),
        .cpu_reset(cpu_reset),
        .done(done),
        .error(error)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [12:0] addr;
        logic [15:0] wdata;
        logic        cpu_rst;
        logic        dn;
        logic        err;
        logic        rdy;
    } vec_t;

    vec_t vecs[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts write strobes as the RAM would see them on a rising edge.
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) we_count++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        @(negedge clk);
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] d);
        applyStimulus(1'b1, d);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 8'h00);
    endtask

    task automatic doReset();
        @(negedge clk);
        resetq       = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetq   = 1'b1;
        we_count = 0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        we_count     = 0;
        resetq       = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        //            v     d      we    addr   wdata     cpu  dn    err   rdy
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 13'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'h02, 1'b0, 13'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 8'h00, 1'b0, 13'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h34, 1'b0, 13'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'h12, 1'b1, 13'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h78, 1'b0, 13'd1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 8'h56, 1'b1, 13'd1, 16'h5678, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h14, 1'b0, 13'd2, 16'h5678, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'hA5, 1'b0, 13'd2, 16'h5678, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset values while resetq is held low.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        @(negedge clk);
        resetq = 1'b1;

        // Good frame, one vector per clock.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].v, vecs[i].d);
            checkOutput($sformatf("vec%0d_we", i), 32'(bus.mem_we), 32'(vecs[i].we));
            checkOutput($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(vecs[i].addr));
            checkOutput($sformatf("vec%0d_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].wdata));
            checkOutput($sformatf("vec%0d_cpu_reset", i), 32'(cpu_reset), 32'(vecs[i].cpu_rst));
            checkOutput($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].dn));
            checkOutput($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].err));
            checkOutput($sformatf("vec%0d_rx_ready", i), 32'(bus.rx_ready), 32'(vecs[i].rdy));
        end
        checkOutput("good_we_count", 32'(we_count), 32'd2);

        // Bad checksum, then the good frame again.
        doReset();
        sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00);
        sendByte(8'h34); sendByte(8'h12); sendByte(8'h78); sendByte(8'h56);
        sendByte(8'h15);
        idleCycle();
        checkOutput("badcs_error", 32'(error), 32'd1);
        checkOutput("badcs_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("badcs_done", 32'(done), 32'd0);
        checkOutput("badcs_rx_ready", 32'(bus.rx_ready), 32'd1);
        checkOutput("badcs_we_count", 32'(we_count), 32'd2);
        sendByte(8'hA5); sendByte(8'h02);
        checkOutput("badcs_error_held", 32'(error), 32'd1);
        sendByte(8'h00);
        checkOutput("badcs_error_cleared", 32'(error), 32'd0);
        sendByte(8'h34); sendByte(8'h12); sendByte(8'h78); sendByte(8'h56);
        sendByte(8'h14);
        checkOutput("resend_done", 32'(done), 32'd1);
        checkOutput("resend_error", 32'(error), 32'd0);
        checkOutput("resend_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("resend_we_count", 32'(we_count), 32'd4);

        // Noise before the sync byte, then a zero-length frame.
        doReset();
        sendByte(8'h00); sendByte(8'hFF); sendByte(8'h5A);
        sendByte(8'hA5); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
        checkOutput("zero_done", 32'(done), 32'd1);
        checkOutput("zero_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("zero_we_count", 32'(we_count), 32'd0);

        // Oversize length aborts on the high length byte; A5 then restarts.
        doReset();
        sendByte(8'hA5); sendByte(8'h01);
        checkOutput("over_error_pre", 32'(error), 32'd0);
        sendByte(8'h20);
        checkOutput("over_error", 32'(error), 32'd1);
        checkOutput("over_cpu_reset", 32'(cpu_reset), 32'd1);
        sendByte(8'hA5); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
        checkOutput("over_restart_done", 32'(done), 32'd1);
        checkOutput("over_restart_error", 32'(error), 32'd0);
        checkOutput("over_we_count", 32'(we_count), 32'd0);

        // Exactly 2^LOG2ABITS words is legal.
        doReset();
        sendByte(8'hA5); sendByte(8'h00); sendByte(8'h20);
        sendByte(8'h11);
        checkOutput("maxlen_error", 32'(error), 32'd0);
        checkOutput("maxlen_done", 32'(done), 32'd0);

        // 0xA5 inside a frame is plain data.
        doReset();
        sendByte(8'hA5); sendByte(8'h01); sendByte(8'h00);
        sendByte(8'hA5); sendByte(8'hA5);
        checkOutput("a5data_wdata", 32'(bus.mem_wdata), 32'h0000A5A5);
        checkOutput("a5data_we", 32'(bus.mem_we), 32'd1);
        sendByte(8'h4A);
        checkOutput("a5data_done", 32'(done), 32'd1);

        // Inter-byte timeout after 16 idle cycles, then a clean frame.
        doReset();
        sendByte(8'hA5); sendByte(8'h01); sendByte(8'h00); sendByte(8'h34);
        repeat (15) idleCycle();
        checkOutput("to_error_15", 32'(error), 32'd0);
        idleCycle();
        checkOutput("to_error_16", 32'(error), 32'd1);
        checkOutput("to_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("to_we_count", 32'(we_count), 32'd0);
        sendByte(8'hA5); sendByte(8'h01); sendByte(8'h00);
        sendByte(8'h34); sendByte(8'h12); sendByte(8'h46);
        checkOutput("to_done", 32'(done), 32'd1);
        checkOutput("to_error_cleared", 32'(error), 32'd0);
        checkOutput("to_we_count_after", 32'(we_count), 32'd1);

        // Asynchronous reset between the low and high byte of a word.
        doReset();
        sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00);
        sendByte(8'h34); sendByte(8'h12); sendByte(8'h78);
        checkOutput("ar_pre_addr", 32'(bus.mem_addr), 32'd1);
        checkOutput("ar_pre_wdata", 32'(bus.mem_wdata), 32'h00001234);
        bus.rx_data = 8'h56;
        #2;
        resetq = 1'b0;
        we_before = we_count;
        #1;
        checkOutput("ar_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("ar_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        checkOutput("ar_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("ar_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("ar_rx_ready", 32'(bus.rx_ready), 32'd1);
        checkOutput("ar_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ar_no_strobe", 32'(we_count), 32'(we_before));
        resetq = 1'b1;
        bus.rx_valid = 1'b0;
        idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
